// File: rtl/instr_sequencer.sv
// Program buffer and issue controller: a host loads instruction words, then the
// block presents them to the processor one at a time, advancing on proc_done.
module instr_sequencer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned IW    = 16
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          load_valid,
  input  logic [IW-1:0] load_data,
  output logic          load_ready,
  input  logic          clear,
  input  logic          start,
  input  logic          stop,
  input  logic          proc_done,
  output logic [IW-1:0] iin,
  output logic          issue,
  output logic          busy,
  output logic          halted,
  output logic [AW-1:0] pc,
  output logic [AW:0]   count
);

  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW:0]   count_q, count_d;
  logic [IW-1:0] iin_q, iin_d;
  logic          wr_en;
  logic [IW-1:0] mem_q [DEPTH];

  logic [AW-1:0] pc_nxt;
  logic          last_word;

  assign pc_nxt    = pc_q + AW'(1);
  assign last_word = ({1'b0, pc_q} == (count_q - CW'(1)));

  assign load_ready = (state_q == StIdle) && (count_q < CW'(DEPTH));
  assign issue      = (state_q == StIssue);
  assign busy       = (state_q == StIssue) || (state_q == StWait);
  assign halted     = (state_q == StDone);
  assign iin        = iin_q;
  assign pc         = pc_q;
  assign count      = count_q;

  // Next-state logic; iin is only reloaded on a transition into StIssue.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    iin_d   = iin_q;
    wr_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clear) begin
          count_d = '0;
        end else if (load_valid && load_ready) begin
          wr_en   = 1'b1;
          count_d = count_q + CW'(1);
        end else if (start && (count_q != '0)) begin
          pc_d    = '0;
          iin_d   = mem_q[0];
          state_d = StIssue;
        end
      end
      StIssue: begin
        state_d = stop ? StIdle : StWait;
      end
      StWait: begin
        // stop wins over proc_done, and pc is left where it was
        if (stop) begin
          state_d = StIdle;
        end else if (proc_done) begin
          if (last_word) begin
            state_d = StDone;
          end else begin
            pc_d    = pc_nxt;
            iin_d   = mem_q[pc_nxt];
            state_d = StIssue;
          end
        end
      end
      StDone: begin
        if (clear) begin
          count_d = '0;
          state_d = StIdle;
        end else if (start) begin
          pc_d    = '0;
          iin_d   = mem_q[0];
          state_d = StIssue;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      pc_q    <= '0;
      count_q <= '0;
      iin_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      iin_q   <= iin_d;
    end
  end

  // Program storage is never reset; count alone defines what is valid.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[count_q[AW-1:0]] <= load_data;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer using an issue scoreboard.
module tb_instr_sequencer;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned IW    = 16;

  logic          clock;
  logic          resetn;
  logic          load_valid;
  logic [IW-1:0] load_data;
  logic          load_ready;
  logic          clear;
  logic          start;
  logic          stop;
  logic          proc_done;
  logic [IW-1:0] iin;
  logic          issue;
  logic          busy;
  logic          halted;
  logic [AW-1:0] pc;
  logic [AW:0]   count;

  instr_sequencer #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .IW   (IW)
  ) u_dut (
    .clock     (clock),
    .resetn    (resetn),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(load_ready),
    .clear     (clear),
    .start     (start),
    .stop      (stop),
    .proc_done (proc_done),
    .iin       (iin),
    .issue     (issue),
    .busy      (busy),
    .halted    (halted),
    .pc        (pc),
    .count     (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] w;
  } sb_item_t;

  sb_item_t   sb_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic [IW-1:0] prog[4] = '{16'hA01C, 16'hA40A, 16'h2080, 16'h8000};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every issue pulse must match the next expected word from the scoreboard.
  always @(negedge clock) begin
    if (resetn && issue) begin
      check_eq("sb_expected_issue", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        sb_item_t it;
        it = sb_q.pop_front();
        check_eq("issue_iin", 32'(iin), 32'(it.w));
        check_eq("issue_pc", 32'(pc), 32'(it.pc));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_word(input logic [IW-1:0] w);
    load_valid = 1'b1;
    load_data  = w;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 4; i++) load_word(prog[i]);
  endtask

  task automatic push_prog(input int n);
    for (int i = 0; i < n; i++) sb_q.push_back('{pc: AW'(i), w: prog[i]});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Bounded wait for an issue pulse, polled just after each rising edge.
  task automatic wait_issue();
    int n = 0;
    while (!issue && n < 20) begin
      tick();
      n++;
    end
    check_eq("issue_seen", 32'(issue), 32'd1);
  endtask

  // Processor model: proc_done arrives d cycles after each issue.
  task automatic run_words(input int n, input int d);
    for (int i = 0; i < n; i++) begin
      wait_issue();
      repeat (d - 1) tick();
      proc_done = 1'b1;
      tick();
      proc_done = 1'b0;
    end
  endtask

  initial begin
    resetn     = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    clear      = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    proc_done  = 1'b0;
    #12;
    check_eq("rst_iin", 32'(iin), 32'd0);
    check_eq("rst_issue", 32'(issue), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_halted", 32'(halted), 32'd0);
    check_eq("rst_pc", 32'(pc), 32'd0);
    check_eq("rst_count", 32'(count), 32'd0);
    resetn = 1'b1;
    #1;
    check_eq("rst_load_ready", 32'(load_ready), 32'd1);
    tick();

    // Basic program run
    load_prog();
    check_eq("count_after_load", 32'(count), 32'd4);
    push_prog(4);
    pulse_start();
    run_words(4, 4);
    check_eq("done_halted", 32'(halted), 32'd1);
    check_eq("done_busy", 32'(busy), 32'd0);
    check_eq("done_pc", 32'(pc), 32'd3);
    check_eq("done_iin_held", 32'(iin), 32'hA01C ^ 32'hA01C ^ 32'h8000);
    check_eq("sb_drained_1", 32'(sb_q.size()), 32'd0);

    // Re-run from DONE
    push_prog(4);
    pulse_start();
    run_words(4, 2);
    check_eq("rerun_halted", 32'(halted), 32'd1);
    check_eq("sb_drained_2", 32'(sb_q.size()), 32'd0);

    // clear and start together in DONE
    clear = 1'b1;
    start = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b0;
    repeat (3) tick();
    check_eq("clr_start_count", 32'(count), 32'd0);
    check_eq("clr_start_halted", 32'(halted), 32'd0);
    check_eq("clr_start_busy", 32'(busy), 32'd0);
    check_eq("clr_start_ready", 32'(load_ready), 32'd1);

    // start with an empty buffer
    pulse_start();
    repeat (4) tick();
    check_eq("empty_start_busy", 32'(busy), 32'd0);
    check_eq("empty_start_halted", 32'(halted), 32'd0);

    // Fill with load_valid held high; the 17th offer is dropped
    load_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      load_data = IW'(16'h1000 + i);
      tick();
    end
    check_eq("full_ready", 32'(load_ready), 32'd0);
    load_data = 16'hDEAD;
    tick();
    load_valid = 1'b0;
    check_eq("full_count", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) sb_q.push_back('{pc: AW'(i), w: IW'(16'h1000 + i)});
    pulse_start();
    run_words(16, 2);
    check_eq("full_halted", 32'(halted), 32'd1);
    check_eq("sb_drained_3", 32'(sb_q.size()), 32'd0);

    // stop together with proc_done in WAIT on pc 1
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("clear_done_count", 32'(count), 32'd0);
    load_prog();
    push_prog(2);
    pulse_start();
    run_words(1, 3);
    wait_issue();
    repeat (2) tick();
    stop      = 1'b1;
    proc_done = 1'b1;
    tick();
    stop      = 1'b0;
    proc_done = 1'b0;
    check_eq("stop_busy", 32'(busy), 32'd0);
    check_eq("stop_pc", 32'(pc), 32'd1);
    check_eq("stop_idle_ready", 32'(load_ready), 32'd1);
    repeat (5) tick();
    check_eq("stop_still_idle", 32'(busy), 32'd0);
    check_eq("sb_drained_4", 32'(sb_q.size()), 32'd0);

    // Asynchronous reset while in WAIT
    push_prog(1);
    pulse_start();
    wait_issue();
    repeat (2) tick();
    check_eq("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check_eq("arst_iin", 32'(iin), 32'd0);
    check_eq("arst_issue", 32'(issue), 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_halted", 32'(halted), 32'd0);
    check_eq("arst_pc", 32'(pc), 32'd0);
    check_eq("arst_count", 32'(count), 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    pulse_start();
    repeat (4) tick();
    check_eq("arst_start_ignored", 32'(busy), 32'd0);
    load_prog();
    push_prog(4);
    pulse_start();
    run_words(4, 2);
    check_eq("post_rst_halted", 32'(halted), 32'd1);
    check_eq("sb_drained_5", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Program buffer and issue controller for the 16-bit processor. A host loads a short program through a valid/ready port. The block then drives the processor's `iin` input one instruction at a time. It advances only when the processor signals end-of-instruction, and stops after the last loaded word, on a stop request, or on reset.

## Interface
Parameters:
- `DEPTH`, 16: program buffer entries; power of two, ≥2.
- `AW`, 4: pointer width, log2(`DEPTH`).
- `IW`, 16: instruction width; matches processor `iin`.

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `load_valid`  in  1  host presents `load_data`.
- `load_data`  in  IW  instruction word to append to the buffer.
- `load_ready`  out  1  buffer accepts a word this cycle.
- `clear`  in  1  empty the buffer; honoured in IDLE and DONE only.
- `start`  in  1  begin execution at entry 0.
- `stop`  in  1  abort execution, return to IDLE.
- `proc_done`  in  1  processor end-of-instruction pulse.
- `iin`  out  IW  instruction driven to the processor.
- `issue`  out  1  one-cycle pulse when a new word appears on `iin`.
- `busy`  out  1  high in ISSUE and WAIT.
- `halted`  out  1  high in DONE.
- `pc`  out  AW  index of the instruction currently on `iin`.
- `count`  out  AW+1  number of loaded words, 0..DEPTH.

## Operation
States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - `load_ready` = (`count` < DEPTH).
  - On `load_valid && load_ready`: mem[`count`] ← `load_data`; `count`+1.
  - `clear`: `count` ← 0; buffer contents are not erased.
  - `start` with `count` > 0: `pc` ← 0; go to ISSUE.
  - `start` with `count` = 0: ignored.
- ISSUE (exactly one cycle):
  - `iin` = mem[`pc`]; `issue` = 1.
  - Go to WAIT, or to IDLE if `stop`.
- WAIT:
  - `iin` holds mem[`pc`].
  - On `proc_done`: if `pc` = `count`−1, go to DONE; else `pc`+1 and go to ISSUE.
  - `stop`: go to IDLE.
- DONE:
  - `halted` = 1; `iin` holds the last word.
  - `start`: `pc` ← 0; go to ISSUE (re-run the same program).
  - `clear`: `count` ← 0; go to IDLE.
- `load_ready` = 0 outside IDLE; words offered then are dropped and not stored.
- Priorities within one cycle:
  - `stop` > `proc_done`; `pc` is not advanced when both are high.
  - In IDLE: `clear` > load > `start`. A load and a `start` in the same cycle store the word and ignore the `start`.
  - In DONE: `clear` > `start`.
- `proc_done` in IDLE, ISSUE or DONE is ignored.
- `iin` changes only on entry to ISSUE; it is otherwise held stable.

## Timing
- Reset (async, `resetn` = 0):
  - State ← IDLE; `iin` = 0, `issue` = 0, `busy` = 0, `halted` = 0, `pc` = 0, `count` = 0.
  - `load_ready` = 1 combinationally once `resetn` is high.
- Reset mid-run aborts immediately. The buffer memory is not reset; it reads as empty because `count` = 0.
- Load: a word is accepted on the rising edge where `load_valid && load_ready`. `count` is visible +1 the next cycle. A full buffer drops `load_ready` the cycle after the DEPTH-th accept.
- Start latency: `start` sampled at edge N. ISSUE during cycle N..N+1: `issue` = 1 and `iin` valid from edge N.
- Advance latency: `proc_done` sampled at edge M in WAIT. The next word appears on `iin` with `issue` = 1 from edge M, so one cycle separates consecutive issues at minimum.
- Completion: `proc_done` on the last word at edge M gives `halted` = 1 and `busy` = 0 from edge M.
- `pc` never exceeds `count`−1; no wrap-around occurs during execution.

## Test plan
- Reset then load A01C, A40A, 2080, 8000 (ldi r0,#28; ldi r1,#10; sub r0,r1; out r0). `start`, with `proc_done` 4 cycles after each `issue`.
  - Required: four `issue` pulses, `iin` sequence A01C→A40A→2080→8000, `pc` 0→3.
  - Required: `halted` = 1 the cycle after the fourth `proc_done`.
- Load 16 words with `load_valid` held high.
  - Required: `load_ready` = 0 after the 16th accept; a 17th word is not stored; `count` = 16.
- `stop` and `proc_done` both asserted in WAIT on `pc` = 1.
  - Required: state IDLE, `pc` stays 1, no further `issue`, `busy` = 0.
- `start` with `count` = 0.
  - Required: state stays IDLE; `issue` never pulses.
- Assert `resetn` = 0 while in WAIT.
  - Required: all outputs at reset values immediately, without waiting for a clock edge.
  - Required: a subsequent `start` is ignored until new words are loaded.
- Reach DONE, then `start`.
  - Required: program re-issues from `pc` = 0 with `iin` = A01C.
- Reach DONE, then `clear` and `start` in the same cycle.
  - Required: IDLE with `count` = 0.
